// File: rtl/branch_ctrl.sv
// Branch/jump resolution and PC sequencing for a single-issue RV32 front end.
// Redirect decision is combinational; PC, flush pulse and branch statistics are registered.
module branch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [31:0]      imm,
   input  logic [31:0]      rs1_data,
   input  logic             BrEq,
   input  logic             BrLT,
   output logic             BrUn,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic             PCSel,
   output logic [31:0]      target,
   output logic             flush,
   output logic             illegal,
   output logic             misaligned,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] taken_count
);

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   logic        isBranch;
   logic        isJal;
   logic        isJalr;
   logic        condMet;
   logic        taken;
   logic        legalBranch;
   logic [31:0] targetSum;

   assign isBranch = (opcode == OP_BRANCH);
   assign isJal    = (opcode == OP_JAL);
   assign isJalr   = (opcode == OP_JALR);

   // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
   always_comb begin
      condMet = 1'b0;
      illegal = 1'b0;
      if (isBranch) begin
         unique case (funct3)
            3'b000:          condMet = BrEq;
            3'b001:          condMet = ~BrEq;
            3'b100, 3'b110:  condMet = BrLT;
            3'b101, 3'b111:  condMet = ~BrLT;
            default:         illegal = 1'b1;
         endcase
      end
   end

   // BGEU/BLTU are the only encodings with funct3[2:1] == 2'b11.
   assign BrUn        = isBranch && (funct3[2:1] == 2'b11);
   assign legalBranch = isBranch && !illegal;
   assign taken       = (legalBranch && condMet) || isJal || isJalr;

   assign targetSum   = (isJalr ? rs1_data : pc) + imm;
   assign target      = isJalr ? {targetSum[31:1], 1'b0} : targetSum;
   assign misaligned  = taken && target[1];
   assign PCSel       = taken && !misaligned;
   assign pc_plus4    = pc + 32'd4;

   // NOTE: state registers use non-blocking assignments; reset is asynchronous and overrides stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         flush       <= 1'b0;
         br_count    <= '0;
         taken_count <= '0;
      end else if (stall) begin
         flush <= 1'b0;
      end else begin
         pc    <= PCSel ? target : pc_plus4;
         flush <= PCSel;
         if (legalBranch) begin
            if (br_count != '1)
               br_count <= br_count + CNT_W'(1);
            if (PCSel && (taken_count != '1))
               taken_count <= taken_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of both statistics counters.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 stall  input  1  hold PC, counters and flush register this cycle.
REQ-007 opcode  input  7  current instruction opcode.
REQ-008 funct3  input  3  current instruction funct3.
REQ-009 imm  input  32  pre-decoded sign-extended immediate.
REQ-010 rs1_data  input  32  rs1 operand, used for the JALR target.
REQ-011 BrEq  input  1  comparator equal result for the current operands.
REQ-012 BrLT  input  1  comparator less-than result for the current operands.
REQ-013 BrUn  output  1  comparator unsigned-compare select.
REQ-014 pc  output  32  registered program counter.
REQ-015 pc_plus4  output  32  pc+4, wrapping modulo 2^32.
REQ-016 PCSel  output  1  combinational redirect select (1 = target).
REQ-017 target  output  32  computed redirect address.
REQ-018 flush  output  1  registered one-cycle pulse following a redirect.
REQ-019 illegal  output  1  BRANCH opcode with an undefined funct3.
REQ-020 misaligned  output  1  taken target not 4-byte aligned.
REQ-021 br_count  output  CNT_W  count of retired conditional branches.
REQ-022 taken_count  output  CNT_W  count of taken conditional branches.

Function
REQ-023 Opcode encodings SHALL be: BRANCH=7'b1100011, JAL=7'b1101111, JALR=7'b1100111; all other opcodes are sequential (not taken).
REQ-024 BrUn SHALL be 1 only when opcode=BRANCH and funct3 is 110 or 111; otherwise it SHALL be 0, combinationally.
REQ-025 For opcode=BRANCH, the condition SHALL be decoded from funct3 as: 000 BrEq; 001 !BrEq; 100 BrLT; 101 !BrLT; 110 BrLT; 111 !BrLT.
REQ-026 For opcode=BRANCH with funct3 010 or 011, illegal SHALL be 1, the branch SHALL be not taken, and it SHALL NOT be counted.
REQ-027 JAL and JALR SHALL always be taken.
REQ-028 target SHALL be pc+imm for BRANCH and JAL, and (rs1_data+imm) with bit 0 cleared for JALR, all modulo 2^32 with no overflow flag.
REQ-029 misaligned SHALL be 1 when the instruction is taken and target[1]=1.
REQ-030 PCSel SHALL be 1 when the instruction is taken and misaligned=0, combinationally in the same cycle, with zero latency from BrEq/BrLT.
REQ-031 On each rising clk edge with stall=0, pc SHALL load target if PCSel=1, else pc_plus4.
REQ-032 On each rising clk edge with stall=0, flush SHALL load PCSel, so it is high exactly one cycle after a redirect.
REQ-033 When stall=1, pc and both counters SHALL hold, flush SHALL load 0, and the combinational outputs SHALL still track their inputs.
REQ-034 On a non-stalled edge with a legal BRANCH, br_count SHALL increment by 1, and taken_count SHALL also increment by 1 if PCSel=1.
REQ-035 Both counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-036 A misaligned taken branch SHALL increment br_count but not taken_count, and pc SHALL advance to pc+4.
REQ-037 When pc=32'hFFFF_FFFC and the instruction is not taken, pc SHALL wrap to 0.

Reset
REQ-038 When rst is asserted, pc SHALL be RESET_PC, flush SHALL be 0, and br_count and taken_count SHALL be 0, immediately and independent of clk.
REQ-039 rst SHALL override stall and any in-flight redirect; the first edge after rst deasserts SHALL behave as a normal cycle from RESET_PC.
REQ-040 After reset, combinational outputs (BrUn, PCSel, target, illegal, misaligned, pc_plus4) SHALL derive from the current inputs and the reset pc.

Verification
REQ-041 pc=0x100, BRANCH funct3=000, BrEq=1, imm=0x20 -> PCSel=1, target=0x120; next edge pc=0x120, flush=1, br_count=1, taken_count=1.
REQ-042 BRANCH funct3=111, BrLT=1 -> BrUn=1, PCSel=0; next edge pc=pc+4, br_count increments, taken_count unchanged.
REQ-043 JALR, rs1_data=0x203, imm=0 -> target=0x202, misaligned=1, PCSel=0; next edge pc=pc+4, counters unchanged.
REQ-044 Taken BEQ with stall=1 for 3 cycles -> pc, counters and flush=0 hold; the first non-stalled edge redirects and flush=1 the following cycle.
REQ-045 Preload br_count=2^CNT_W-1 via repeated branches, then another legal branch -> br_count stays at all-ones; BRANCH funct3=010 -> illegal=1 and no count.
REQ-046 Assert rst asynchronously mid-cycle while a redirect is pending -> pc=RESET_PC, flush=0 and counters=0 before the next edge.
